// File: rtl/qspi_line_fetcher.sv
// Quad-output (6Bh) SPI flash line fetcher with double-buffered nibble line store.
// Optional abort input enabled by defining QSPI_FETCH_ABORT_EN.
module qspi_line_fetcher #(
  parameter int         NIBBLES   = 136,
  parameter int         DUMMY_CYC = 8,
  parameter logic [7:0] CMD       = 8'h6B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] addr,
`ifdef QSPI_FETCH_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic        spi_cs,
  output logic        spi_out0,
  output logic        spi_dir0,
  input  logic [3:0]  spi_in,
  input  logic [7:0]  rd_addr,
  output logic [3:0]  rd_data
);

  localparam int CW = 9;
  localparam logic [CW-1:0] C_ADDR  = CW'(8);
  localparam logic [CW-1:0] C_DUMMY = CW'(32);
  localparam logic [CW-1:0] C_DATA  = CW'(32 + DUMMY_CYC);
  localparam logic [CW-1:0] C_DONE  = CW'(32 + DUMMY_CYC + NIBBLES);
  localparam logic [7:0]    RD_LIM  = 8'(NIBBLES);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [23:0]     r_addr_q;
  logic            r_sel;
  logic            r_cs, r_out0, r_dir0, r_busy, r_done;
  logic            w_cs_nxt, w_out0_nxt, w_dir0_nxt, w_busy_nxt, w_done_nxt;
  logic            w_abort;
  logic            w_start_ok;
  logic [7:0]      w_k;
  logic [3:0]      r_bank0 [0:NIBBLES-1];
  logic [3:0]      r_bank1 [0:NIBBLES-1];

`ifdef QSPI_FETCH_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_k        = r_cnt[7:0] - C_DATA[7:0];

  // State and burst-cycle counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: phase boundaries are fixed burst-cycle numbers
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CMD;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        w_cnt_nxt = r_cnt + 9'd1;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_nxt < C_ADDR) begin
          w_state_nxt = S_CMD;
        end else if (w_cnt_nxt < C_DUMMY) begin
          w_state_nxt = S_ADDR;
        end else if (w_cnt_nxt < C_DATA) begin
          w_state_nxt = S_DUMMY;
        end else if (w_cnt_nxt < C_DONE) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode of the upcoming state, so the pins are registered on the same edge
  always_comb begin
    w_cs_nxt   = 1'b0;
    w_out0_nxt = 1'b0;
    w_dir0_nxt = 1'b0;
    w_busy_nxt = 1'b1;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE:  w_busy_nxt = 1'b0;
      S_CMD: begin
        w_cs_nxt   = 1'b1;
        w_out0_nxt = CMD[3'd7 - w_cnt_nxt[2:0]];
      end
      S_ADDR: begin
        w_cs_nxt   = 1'b1;
        w_out0_nxt = r_addr_q[5'd31 - w_cnt_nxt[4:0]];
      end
      S_DUMMY, S_DATA: begin
        w_cs_nxt   = 1'b1;
        w_dir0_nxt = 1'b1;
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: w_busy_nxt = 1'b0;
    endcase
  end

  // Registered SPI pins and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs   <= 1'b0;
      r_out0 <= 1'b0;
      r_dir0 <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cs   <= w_cs_nxt;
      r_out0 <= w_out0_nxt;
      r_dir0 <= w_dir0_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Flash address latch and display-bank select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_q <= 24'h000000;
      r_sel    <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_addr_q <= addr;
      end
      if (r_state == S_DONE) begin
        r_sel <= ~r_sel;
      end
    end
  end

  // Nibble capture into the bank not currently displayed
  always_ff @(posedge clk) begin
    if (r_state == S_DATA) begin
      if (r_sel) begin
        r_bank0[w_k] <= spi_in;
      end else begin
        r_bank1[w_k] <= spi_in;
      end
    end
  end

  // Display-bank read port; out-of-range indices read as zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= 4'h0;
    end else if (rd_addr < RD_LIM) begin
      rd_data <= r_sel ? r_bank1[rd_addr] : r_bank0[rd_addr];
    end else begin
      rd_data <= 4'h0;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign spi_cs   = r_cs;
  assign spi_out0 = r_out0;
  assign spi_dir0 = r_dir0;

endmodule

// File: tb/tb_qspi_line_fetcher.sv
// Directed, self-checking bench for qspi_line_fetcher with a simple flash nibble model.
module tb_qspi_line_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = 24'h000000;
  logic [3:0]  spi_in = 4'h0;
  logic [7:0]  rd_addr = 8'd200;
  logic        busy, done, spi_cs, spi_out0, spi_dir0;
  logic [3:0]  rd_data;
`ifdef QSPI_FETCH_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] ra;
    logic [3:0] ea;
    logic [3:0] eb;
  } rd_vec_t;
  rd_vec_t tbl [9];

  qspi_line_fetcher dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr     (addr),
`ifdef QSPI_FETCH_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .spi_cs   (spi_cs),
    .spi_out0 (spi_out0),
    .spi_dir0 (spi_dir0),
    .spi_in   (spi_in),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pattern 0: k[3:0], pattern 1: (7k+3)[3:0], otherwise constant 9
  function automatic logic [3:0] pat_val(input int p, input int k);
    int v;
    case (p)
      0:       v = k;
      1:       v = k * 7 + 3;
      default: v = 9;
    endcase
    return v[3:0];
  endfunction

  task automatic rd_chk(input logic [7:0] a, input logic [3:0] exp, input string nm);
    @(posedge clk); #1;
    rd_addr = a;
    @(posedge clk); #1;
    chk($sformatf("%s[%0d]", nm, a), rd_data, exp);
  endtask

  // Full burst; returns at the negedge of cycle 177 (one cycle after DONE)
  task automatic burst(input logic [23:0] a, input int p, input int ign_c,
                       input int rd_c, input logic [7:0] rd_a);
    logic [31:0] stream;
    int ndone;
    stream = {8'h6B, a};
    ndone = 0;
    addr = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= 176; c++) begin
      spi_in = (c >= 40 && c < 176) ? pat_val(p, c - 40) : 4'h0;
      start = (ign_c >= 0) && (c == ign_c || c == 176);
      if (c == ign_c) addr = 24'h5A5A5A;
      if (c == rd_c) rd_addr = rd_a;
      @(negedge clk);
      if (done) ndone++;
      chk($sformatf("cs c=%0d", c), spi_cs, c < 176);
      chk($sformatf("dir0 c=%0d", c), spi_dir0, c >= 32 && c < 176);
      chk($sformatf("busy c=%0d", c), busy, 1);
      chk($sformatf("done c=%0d", c), done, c == 176);
      if (c < 32) chk($sformatf("out0 c=%0d", c), spi_out0, stream[31-c]);
      else if (c < 40) chk($sformatf("out0_dummy c=%0d", c), spi_out0, 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    chk("busy_c177", busy, 0);
    chk("cs_c177", spi_cs, 0);
    chk("dir0_c177", spi_dir0, 0);
    chk("done_c177", done, 0);
    chk("done_count", ndone, 1);
  endtask

  // Burst interrupted at cycle cut_c by reset (kind 0) or abort (kind 1)
  task automatic burst_cut(input logic [23:0] a, input int p, input int cut_c, input int kind);
    int ndone;
    ndone = 0;
    addr = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < cut_c; c++) begin
      spi_in = (c >= 40) ? pat_val(p, c - 40) : 4'h0;
      @(posedge clk); #1;
    end
    chk("cs_before_cut", spi_cs, 1);
    if (kind == 0) begin
      reset = 1'b0;
      #1;
      chk("cs_async_reset", spi_cs, 0);
      chk("busy_async_reset", busy, 0);
      chk("dir0_async_reset", spi_dir0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
    end else begin
`ifdef QSPI_FETCH_ABORT_EN
      abort = 1'b1;
      @(negedge clk);
      chk("cs_abort_same_cycle", spi_cs, 1);
      @(posedge clk); #1;
      abort = 1'b0;
      chk("cs_after_abort", spi_cs, 0);
      chk("busy_after_abort", busy, 0);
      chk("dir0_after_abort", spi_dir0, 0);
`endif
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) ndone++;
      chk($sformatf("cs_quiet i=%0d", i), spi_cs, 0);
    end
    chk("no_done_after_cut", ndone, 0);
  endtask

  initial begin
    tbl[0] = '{8'd0,   4'h0, 4'h3};
    tbl[1] = '{8'd1,   4'h1, 4'hA};
    tbl[2] = '{8'd15,  4'hF, 4'hC};
    tbl[3] = '{8'd16,  4'h0, 4'h3};
    tbl[4] = '{8'd100, 4'h4, 4'hF};
    tbl[5] = '{8'd135, 4'h7, 4'h4};
    tbl[6] = '{8'd136, 4'h0, 4'h0};
    tbl[7] = '{8'd200, 4'h0, 4'h0};
    tbl[8] = '{8'd255, 4'h0, 4'h0};

    repeat (3) @(negedge clk);
    chk("reset_cs", spi_cs, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd_data", rd_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk($sformatf("idle i=%0d", i), {spi_cs, spi_dir0, spi_out0, busy, done, rd_data}, 0);
    end

    burst(24'h000A40, 0, -1, -1, 8'd0);
    for (int k = 0; k < 136; k++) rd_chk(8'(k), pat_val(0, k), "sweepA");
    rd_chk(8'd136, 4'h0, "rd_oob");
    for (int i = 0; i < 9; i++) rd_chk(tbl[i].ra, tbl[i].ea, "tblA");

    burst(24'h123456, 1, -1, 176, 8'd1);
    chk("rd_in_done_old_bank", rd_data, 4'h1);
    @(posedge clk); #1;
    chk("rd_after_done_new_bank", rd_data, 4'hA);
    for (int i = 0; i < 9; i++) rd_chk(tbl[i].ra, tbl[i].eb, "tblB");

    burst(24'hABCDEF, 0, 50, -1, 8'd0);
    burst(24'h000A40, 1, -1, -1, 8'd0);
    for (int i = 0; i < 9; i++) rd_chk(tbl[i].ra, tbl[i].eb, "tblB2");

    burst_cut(24'h000100, 2, 100, 0);
    for (int i = 0; i < 9; i++) rd_chk(tbl[i].ra, tbl[i].eb, "tblB_after_reset");

`ifdef QSPI_FETCH_ABORT_EN
    burst_cut(24'h000200, 2, 100, 1);
    for (int i = 0; i < 9; i++) rd_chk(tbl[i].ra, tbl[i].eb, "tblB_after_abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
